// File: rtl/canvas_slot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : canvas_slot_sequencer
// Purpose  : Sweeps a whole canvas snapshot between the shadow canvas RAM and
//            one of two slot RAM regions.
//            Load (iOp=0) reads the selected slot and plots every pixel to the
//            VGA adapter. Save (iOp=1) reads the canvas and writes every pixel
//            into the selected slot.
// Ports    : iClk, iResetn (async, active-low)
//            iStart/iOp/iSlot - request, operation and slot (latched at start)
//            oBusy/oDone      - activity flag and one-cycle completion pulse
//            oSlotAddr/oSlotWe/oSlotWData/iSlotRData - slot RAM port
//            oCanvasAddr/iCanvasRData                - canvas RAM read port
//            oX/oY/oColour/oPlot                     - VGA plot port
// Revision : 1.0 - initial release
// ============================================================================
module canvas_slot_sequencer #(
   parameter int X_MAX   = 159,
   parameter int Y_MAX   = 119,
   parameter int X_W     = 8,
   parameter int Y_W     = 7,
   parameter int ADDR_W  = 15,
   parameter int COLOR_W = 3
) (
   input  logic               iClk,
   input  logic               iResetn,
   input  logic               iStart,
   input  logic               iOp,
   input  logic               iSlot,
   output logic               oBusy,
   output logic               oDone,
   output logic [ADDR_W:0]    oSlotAddr,
   output logic               oSlotWe,
   output logic [COLOR_W-1:0] oSlotWData,
   input  logic [COLOR_W-1:0] iSlotRData,
   output logic [ADDR_W-1:0]  oCanvasAddr,
   input  logic [COLOR_W-1:0] iCanvasRData,
   output logic [X_W-1:0]     oX,
   output logic [Y_W-1:0]     oY,
   output logic [COLOR_W-1:0] oColour,
   output logic               oPlot
);

   localparam logic [X_W-1:0] c_xMax = X_W'(X_MAX);
   localparam logic [Y_W-1:0] c_yMax = Y_W'(Y_MAX);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SWEEP = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t r_state;
   state_t w_stateNext;

   // Issue-side counters; r_addr tracks y*(X_MAX+1)+x incrementally.
   logic [X_W-1:0]    r_x;
   logic [Y_W-1:0]    r_y;
   logic [ADDR_W-1:0] r_addr;
   logic              r_op;
   logic              r_slot;

   // One-stage pipeline aligned with the 1-cycle RAM read latency.
   logic              r_pValid;
   logic [ADDR_W-1:0] r_pAddr;
   logic [X_W-1:0]    r_pX;
   logic [Y_W-1:0]    r_pY;

   logic w_lastIssue;
   logic w_act;

   assign w_lastIssue = (r_state == S_SWEEP) && (r_x == c_xMax) && (r_y == c_yMax);
   // The pipeline valid bit is only meaningful while sweeping/flushing.
   assign w_act       = r_pValid && ((r_state == S_SWEEP) || (r_state == S_FLUSH));

   always_ff @(posedge iClk or negedge iResetn) begin
      if (!iResetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_ff @(posedge iClk or negedge iResetn) begin
      if (!iResetn) begin
         r_x      <= '0;
         r_y      <= '0;
         r_addr   <= '0;
         r_op     <= 1'b0;
         r_slot   <= 1'b0;
         r_pValid <= 1'b0;
         r_pAddr  <= '0;
         r_pX     <= '0;
         r_pY     <= '0;
      end else begin
         r_pValid <= (r_state == S_SWEEP);
         if (r_state == S_SWEEP) begin
            r_pAddr <= r_addr;
            r_pX    <= r_x;
            r_pY    <= r_y;
         end

         case (r_state)
            S_IDLE: begin
               if (iStart) begin
                  r_op   <= iOp;
                  r_slot <= iSlot;
                  r_x    <= '0;
                  r_y    <= '0;
                  r_addr <= '0;
               end
            end
            S_SWEEP: begin
               if (w_lastIssue) begin
                  // Park the counters at 0 once the final pixel is issued.
                  r_x    <= '0;
                  r_y    <= '0;
                  r_addr <= '0;
               end else begin
                  r_addr <= r_addr + 1'b1;
                  if (r_x == c_xMax) begin
                     r_x <= '0;
                     r_y <= r_y + 1'b1;
                  end else begin
                     r_x <= r_x + 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      w_stateNext = r_state;
      oBusy       = (r_state != S_IDLE);
      oDone       = 1'b0;
      oSlotAddr   = '0;
      oSlotWe     = 1'b0;
      oSlotWData  = '0;
      oCanvasAddr = '0;
      oX          = '0;
      oY          = '0;
      oColour     = '0;
      oPlot       = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (iStart) begin
               w_stateNext = S_SWEEP;
            end
         end
         S_SWEEP: begin
            if (w_lastIssue) begin
               w_stateNext = S_FLUSH;
            end
         end
         S_FLUSH: begin
            w_stateNext = S_DONE;
         end
         S_DONE: begin
            oDone       = 1'b1;
            w_stateNext = S_IDLE;
         end
         default: begin
            w_stateNext = S_IDLE;
         end
      endcase

      // Read side: load reads the slot, save reads the canvas.
      if (r_state == S_SWEEP) begin
         if (!r_op) begin
            oSlotAddr = {r_slot, r_addr};
         end else begin
            oCanvasAddr = r_addr;
         end
      end

      // Act side: the registered stage consumes the data returned this cycle.
      // In save the slot port carries only writes, so no read/write clash.
      if (w_act) begin
         if (!r_op) begin
            oPlot   = 1'b1;
            oX      = r_pX;
            oY      = r_pY;
            oColour = iSlotRData;
         end else begin
            oSlotWe    = 1'b1;
            oSlotAddr  = {r_slot, r_pAddr};
            oSlotWData = iCanvasRData;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_canvas_slot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_canvas_slot_sequencer
// Purpose  : Scoreboard bench. A small-geometry instance (4x2) runs directed
//            and random load/save operations against RAM models; a default
//            geometry instance (160x120) runs one full-screen load in parallel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_canvas_slot_sequencer;

   // ---------------- small configuration ----------------
   localparam int SW = 4;
   localparam int SH = 2;
   localparam int SN = SW * SH;
   // ---------------- full configuration -----------------
   localparam int FW = 160;
   localparam int FH = 120;
   localparam int FN = FW * FH;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   function automatic void chk(bit ok, string name, string detail);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: %s", name, detail);
      end
   endfunction

   // ---------------- small DUT ----------------
   logic       rstn = 1'b0;
   logic       start = 1'b0, op = 1'b0, slot = 1'b0;
   logic       busy, done, slotWe, plot;
   logic [3:0] slotAddr;
   logic [2:0] slotWData, colour, canvasAddr;
   logic [2:0] slotRData, canvasRData;
   logic [1:0] x;
   logic [0:0] y;

   canvas_slot_sequencer #(
      .X_MAX(SW-1), .Y_MAX(SH-1), .X_W(2), .Y_W(1), .ADDR_W(3), .COLOR_W(3)
   ) dut (
      .iClk(clk), .iResetn(rstn), .iStart(start), .iOp(op), .iSlot(slot),
      .oBusy(busy), .oDone(done), .oSlotAddr(slotAddr), .oSlotWe(slotWe),
      .oSlotWData(slotWData), .iSlotRData(slotRData), .oCanvasAddr(canvasAddr),
      .iCanvasRData(canvasRData), .oX(x), .oY(y), .oColour(colour), .oPlot(plot)
   );

   // RAM models with 1-cycle read latency plus a backdoor preload port.
   logic [2:0] slotRam [2*SN];
   logic [2:0] canvasRam [SN];
   logic       bdSlotWe = 1'b0, bdCanWe = 1'b0;
   logic [3:0] bdSlotAddr = '0;
   logic [2:0] bdCanAddr = '0, bdSlotData = '0, bdCanData = '0;

   always @(posedge clk) begin
      slotRData   <= slotRam[slotAddr];
      canvasRData <= canvasRam[canvasAddr];
      if (slotWe)   slotRam[slotAddr]    <= slotWData;
      if (bdSlotWe) slotRam[bdSlotAddr]  <= bdSlotData;
      if (bdCanWe)  canvasRam[bdCanAddr] <= bdCanData;
   end

   // ---------------- reference model + scoreboard ----------------
   int refSlot [2*SN];
   int refCanvas [SN];

   typedef struct {
      int kind;   // 0 plot (a=x,b=y), 1 slot write (a=slot address), 2 done
      int cyc;
      int a;
      int b;
      int d;
   } item_t;
   item_t expQ[$];

   // Spec cycle 0 is the cycle in which iStart is sampled: pixel k acts in
   // cycle base+k+2 and oDone is in base+N+2.
   task automatic pushOp(int opv, int slotv, int base);
      for (int k = 0; k < SN; k++) begin
         if (opv == 0) begin
            expQ.push_back('{0, base + k + 2, k % SW, k / SW, refSlot[slotv*SN + k]});
         end else begin
            expQ.push_back('{1, base + k + 2, slotv*SN + k, 0, refCanvas[k]});
            refSlot[slotv*SN + k] = refCanvas[k];
         end
      end
      expQ.push_back('{2, base + SN + 2, 0, 0, 0});
   endtask

   always @(negedge clk) begin
      if (rstn) begin
         chk(!(plot && slotWe) && (plot || (x == 0 && y == 0 && colour == 0)) &&
             (slotWe || slotWData == 0), "quiet",
             $sformatf("plot=%0b we=%0b x=%0d y=%0d col=%0d wdata=%0d, required exclusive strobes and zero idle outputs",
                       plot, slotWe, x, y, colour, slotWData));
         if (plot || slotWe || done) begin
            int gk, ga, gb, gd;
            if (plot) begin
               gk = 0; ga = int'(x); gb = int'(y); gd = int'(colour);
            end else if (slotWe) begin
               gk = 1; ga = int'(slotAddr); gb = 0; gd = int'(slotWData);
            end else begin
               gk = 2; ga = 0; gb = 0; gd = 0;
            end
            if (expQ.size() == 0) begin
               chk(1'b0, "unexpected",
                   $sformatf("kind=%0d at cyc %0d, required no event", gk, cyc));
            end else begin
               item_t e;
               e = expQ.pop_front();
               chk((gk == e.kind) && (cyc == e.cyc) && (ga == e.a) && (gb == e.b) &&
                   (gd == e.d) && (gk != 2 || busy) && !(plot && done), "event",
                   $sformatf("got kind=%0d cyc=%0d a=%0d b=%0d d=%0d busy=%0b, required kind=%0d cyc=%0d a=%0d b=%0d d=%0d",
                             gk, cyc, ga, gb, gd, busy, e.kind, e.cyc, e.a, e.b, e.d));
            end
         end
      end
   end

   // ---------------- full DUT ----------------
   logic        rstnF = 1'b0;
   logic        startF = 1'b0;
   logic        busyF, doneF, slotWeF, plotF;
   logic [15:0] slotAddrF;
   logic [2:0]  slotWDataF, colourF, slotRDataF;
   logic [2:0]  canvasRDataF = '0;
   logic [14:0] canvasAddrF;
   logic [7:0]  xF;
   logic [6:0]  yF;

   canvas_slot_sequencer dutF (
      .iClk(clk), .iResetn(rstnF), .iStart(startF), .iOp(1'b0), .iSlot(1'b1),
      .oBusy(busyF), .oDone(doneF), .oSlotAddr(slotAddrF), .oSlotWe(slotWeF),
      .oSlotWData(slotWDataF), .iSlotRData(slotRDataF), .oCanvasAddr(canvasAddrF),
      .iCanvasRData(canvasRDataF), .oX(xF), .oY(yF), .oColour(colourF), .oPlot(plotF)
   );

   // Slot content for the full run is a fixed function of the address.
   function automatic logic [2:0] romF(int a);
      return 3'((a * 5 + (a >> 4)) & 7);
   endfunction

   always @(posedge clk) slotRDataF <= romF(int'(slotAddrF));

   int baseF = 0;
   int kF = 0;
   bit armedF = 1'b0;
   bit doneSeenF = 1'b0;

   initial begin
      wait (rstnF === 1'b1);
      @(negedge clk);
      startF = 1'b1;
      baseF  = cyc;
      armedF = 1'b1;
      @(negedge clk);
      startF = 1'b0;
   end

   always @(negedge clk) begin
      if (rstnF && armedF) begin
         if (plotF) begin
            chk(kF < FN && int'(xF) == kF % FW && int'(yF) == kF / FW &&
                colourF == romF(FN + kF) && cyc == baseF + kF + 2 && !slotWeF, "full_plot",
                $sformatf("k=%0d got x=%0d y=%0d col=%0d cyc=%0d we=%0b, required x=%0d y=%0d col=%0d cyc=%0d",
                          kF, xF, yF, colourF, cyc, slotWeF, kF % FW, kF / FW, romF(FN + kF), baseF + kF + 2));
            kF++;
         end else if (slotWeF) begin
            chk(1'b0, "full_we", $sformatf("write at cyc %0d, required none during load", cyc));
         end
         if (doneF) begin
            chk(kF == FN && cyc == baseF + FN + 2 && !doneSeenF, "full_done",
                $sformatf("got plots=%0d cyc=%0d, required plots=%0d cyc=%0d", kF, cyc, FN, baseF + FN + 2));
            doneSeenF = 1'b1;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wrSlot(int a, int d);
      @(negedge clk);
      bdSlotWe = 1'b1; bdSlotAddr = 4'(a); bdSlotData = 3'(d);
      refSlot[a] = d;
   endtask

   task automatic wrCanvas(int a, int d);
      @(negedge clk);
      bdCanWe = 1'b1; bdCanAddr = 3'(a); bdCanData = 3'(d);
      refCanvas[a] = d;
   endtask

   task automatic bdOff();
      @(negedge clk);
      bdSlotWe = 1'b0; bdCanWe = 1'b0;
   endtask

   task automatic startOp(int opv, int slotv);
      @(negedge clk);
      op = opv[0]; slot = slotv[0]; start = 1'b1;
      pushOp(opv, slotv, cyc);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain(string name);
      int n = 0;
      while (expQ.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(expQ.size() == 0, name,
          $sformatf("%0d events outstanding after %0d cycles, required 0", expQ.size(), n));
      expQ.delete();
      repeat (2) @(negedge clk);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int base;
      repeat (3) @(negedge clk);
      chk(!busy && !done && !plot && !slotWe && slotAddr == 0 && slotWData == 0 &&
          canvasAddr == 0 && x == 0 && y == 0 && colour == 0 &&
          !busyF && !doneF && !plotF && !slotWeF, "reset_state",
          $sformatf("busy=%0b done=%0b plot=%0b we=%0b saddr=%0d caddr=%0d, required all 0",
                    busy, done, plot, slotWe, slotAddr, canvasAddr));
      rstn = 1'b1;
      rstnF = 1'b1;

      // Slot 1 = addr[2:0], slot 0 random, canvas = 7-addr.
      for (int a = 0; a < SN; a++) wrSlot(SN + a, a & 7);
      for (int a = 0; a < SN; a++) wrSlot(a, int'($urandom_range(0, 7)));
      for (int a = 0; a < SN; a++) wrCanvas(a, 7 - a);
      bdOff();

      startOp(0, 1);
      drain("load_slot1");
      startOp(1, 0);
      drain("save_slot0");

      // Save into slot 1 with new canvas, then read slot 0 back.
      for (int a = 0; a < SN; a++) wrCanvas(a, int'($urandom_range(0, 7)));
      bdOff();
      startOp(1, 1);
      drain("save_slot1");
      startOp(0, 0);
      drain("slot0_intact");

      // iStart held high; op/slot toggled after acceptance.
      @(negedge clk);
      op = 1'b0; slot = 1'b1; start = 1'b1;
      base = cyc;
      pushOp(0, 1, base);
      forever begin
         @(negedge clk);
         if (cyc >= base + SN + 3) break;
         op = 1'($urandom); slot = 1'($urandom);
      end
      op = 1'b1; slot = 1'b1;
      pushOp(1, 1, cyc);
      @(negedge clk);
      start = 1'b0;
      drain("held_start");

      // Reset in cycle 5 of a load.
      startOp(0, 1);
      repeat (4) @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      chk(!busy && !done && !plot && !slotWe && slotAddr == 0 && slotWData == 0 &&
          canvasAddr == 0 && x == 0 && y == 0 && colour == 0, "async_reset",
          $sformatf("busy=%0b done=%0b plot=%0b we=%0b saddr=%0d x=%0d y=%0d col=%0d, required all 0",
                    busy, done, plot, slotWe, slotAddr, x, y, colour));
      expQ.delete();
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      repeat (12) @(negedge clk);
      chk(!busy, "idle_after_reset", $sformatf("busy=%0b, required 0", busy));
      startOp(0, 1);
      drain("restart_after_reset");

      // Random operations.
      for (int i = 0; i < 12; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            for (int a = 0; a < SN; a++) wrCanvas(a, int'($urandom_range(0, 7)));
            bdOff();
         end
         repeat ($urandom_range(0, 3)) @(negedge clk);
         startOp(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
         drain("random_op");
      end

      begin
         int n = 0;
         while (!doneSeenF && n < 25000) begin
            @(negedge clk);
            n++;
         end
      end
      chk(doneSeenF && kF == FN, "full_load",
          $sformatf("done=%0b plots=%0d, required done=1 plots=%0d", doneSeenF, kF, FN));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/canvas_slot_sequencer.md
Name: canvas_slot_sequencer

Overview:
Sequences the memory datapath for save and load of whole-canvas snapshots to or from two on-chip slot RAM regions.
- Load: sweeps every pixel of the selected slot and plots it to the VGA adapter.
- Save: sweeps the shadow canvas RAM and writes each pixel into the selected slot.
- Started by the drawing control FSM on entry to a slot-change state. Its oDone feeds that FSM's iDone while the memory datapath is selected.

Parameters:
X_MAX, 159, last x coordinate (screen width minus 1)
Y_MAX, 119, last y coordinate
X_W, 8, x coordinate width
Y_W, 7, y coordinate width
ADDR_W, 15, linear pixel address width (must hold (X_MAX+1)*(Y_MAX+1)-1)
COLOR_W, 3, pixel colour width

Ports:
iClk  in  1  clock
iResetn  in  1  reset, asynchronous, active-low
iStart  in  1  request; sampled only in IDLE
iOp  in  1  0 = load (slot to screen), 1 = save (canvas to slot)
iSlot  in  1  slot select; latched at start
oBusy  out  1  high from the cycle after start acceptance until oDone inclusive
oDone  out  1  one-cycle completion pulse
oSlotAddr  out  ADDR_W+1  slot RAM address, {slot, pixel address}
oSlotWe  out  1  slot RAM write enable
oSlotWData  out  COLOR_W  slot RAM write data
iSlotRData  in  COLOR_W  slot RAM read data; 1-cycle read latency
oCanvasAddr  out  ADDR_W  shadow canvas RAM read address
iCanvasRData  in  COLOR_W  canvas read data; 1-cycle read latency
oX  out  X_W  VGA plot x
oY  out  Y_W  VGA plot y
oColour  out  COLOR_W  VGA plot colour
oPlot  out  1  VGA plot strobe; the adapter accepts one pixel per cycle, no back-pressure

Behaviour:
- Reset (async, iResetn low):
  - state = IDLE; all counters 0; latched op/slot 0.
  - oBusy, oDone, oSlotWe, oPlot = 0; all address, data and coordinate outputs = 0.
  - Reset mid-sweep abandons the operation immediately: no further writes or plots, no oDone.
- States: IDLE, SWEEP, FLUSH, DONE.
- IDLE:
  - On iStart = 1 at a rising edge, latch iOp and iSlot, clear x/y/addr counters, and go to SWEEP.
  - iStart while not in IDLE is ignored. No queuing.
- SWEEP:
  - Each cycle, drive read address addr = y*(X_MAX+1)+x, held as an incrementing counter with no multiplier.
  - Load reads oSlotAddr = {slot, addr}. Save reads oCanvasAddr = addr.
  - Then advance: x++; when x == X_MAX, x = 0 and y++.
  - When (x, y) == (X_MAX, Y_MAX) is issued, go to FLUSH.
- Pipeline:
  - A one-stage register holds the issued addr/x/y plus a valid bit.
  - The cycle after a read is issued, the registered stage acts with the returned data.
  - Load: oPlot = 1, oX/oY = registered coords, oColour = iSlotRData.
  - Save: oSlotWe = 1, oSlotAddr = {slot, registered addr}, oSlotWData = iCanvasRData.
  - In save, the read address (canvas) and write address (slot) are on separate RAMs, so there is no port conflict.
- FLUSH: performs the write or plot for the last pixel. Issues no new read. Next state is DONE.
- DONE: oDone = 1 for exactly one cycle, then IDLE.
- Latency: if start is accepted at edge 0, pixel k is written or plotted in cycle k+2. With N = (X_MAX+1)*(Y_MAX+1), oDone is high in cycle N+2.
- oSlotWe and oPlot are never both high. oSlotWe is never high during load; oPlot is never high during save.
- Outside SWEEP/FLUSH, oSlotWe and oPlot = 0, and coordinate/data outputs are held at 0.
- Changes to iOp or iSlot after start acceptance have no effect until the next start.
- No pixel is skipped or repeated. The x wrap and the y increment happen in the same cycle.

Test Plan:
- Small config (X_MAX=3, Y_MAX=1, N=8):
  - Preload slot 1 with colour = addr[2:0]; pulse iStart with iOp=0, iSlot=1.
  - Required: oPlot high for exactly cycles 2..9; (oX, oY, oColour) = (0,0,0), (1,0,1) … (3,1,7); oDone only in cycle 10; oSlotWe never high.
- Save, iSlot=0, canvas colour = 7-addr:
  - Required: oSlotWe high for 8 cycles; slot addresses {0, 0..7} with data 7..0; oPlot never high; single oDone pulse.
- Save to slot 1 after a save to slot 0:
  - Required: slot-0 contents unchanged; oSlotAddr MSB = 1 on every write.
- iStart held high throughout, with iOp/iSlot toggled during the sweep:
  - Required: exactly one operation with the originally latched op/slot; a new operation starts only on a start sampled after return to IDLE.
- Assert iResetn low at cycle 5 of a load:
  - Required: oPlot drops asynchronously; all outputs 0; no oDone; the next iStart restarts from (0,0).
- Full default config (160x120) load:
  - Required: 19200 plots; last plot at (159,119); oDone at cycle 19202; x never exceeds 159 and y never exceeds 119.
